// File: rtl/hex_digits_write_arbiter.sv
// Round-robin arbiter sharing the hex-digit PIO write port between two requesters.
// Repeated values are acknowledged without a bus cycle; real writes lock the port for HOLD_CYCLES.
module hex_digits_write_arbiter #(
    parameter int HOLD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [15:0] data0,
    output logic        ack0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        ack1,
    output logic        chipselect,
    output logic        write_n,
    output logic [1:0]  address,
    output logic [31:0] writedata,
    output logic [15:0] shadow,
    output logic        busy
);

    localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        SKIP  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state_q;
    logic             last_grant_q;
    logic [15:0]      data_q;
    logic [15:0]      shadow_q;
    logic             shadow_valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             chipselect_q;
    logic             write_n_q;
    logic [31:0]      writedata_q;
    logic             ack0_q;
    logic             ack1_q;
    logic             busy_q;

    logic             grant_any_d;
    logic             grant_sel_d;
    logic [15:0]      grant_data_d;
    logic             grant_dup_d;

    // With both requesting, the one not served last wins.
    always_comb begin
        grant_any_d  = req0 | req1;
        grant_sel_d  = 1'b0;
        if (req0 && req1) begin
            grant_sel_d = ~last_grant_q;
        end else if (req1) begin
            grant_sel_d = 1'b1;
        end
        grant_data_d = grant_sel_d ? data1 : data0;
        grant_dup_d  = shadow_valid_q && (grant_data_d == shadow_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            data_q         <= '0;
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
            cnt_q          <= '0;
            chipselect_q   <= 1'b0;
            write_n_q      <= 1'b1;
            writedata_q    <= '0;
            ack0_q         <= 1'b0;
            ack1_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            // Bus strobes and acks are single-cycle pulses unless reasserted below.
            chipselect_q <= 1'b0;
            write_n_q    <= 1'b1;
            writedata_q  <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_any_d) begin
                        data_q       <= grant_data_d;
                        last_grant_q <= grant_sel_d;
                        busy_q       <= 1'b1;
                        ack0_q       <= ~grant_sel_d;
                        ack1_q       <= grant_sel_d;
                        if (grant_dup_d) begin
                            state_q <= SKIP;
                        end else begin
                            state_q      <= WRITE;
                            chipselect_q <= 1'b1;
                            write_n_q    <= 1'b0;
                            writedata_q  <= {16'h0000, grant_data_d};
                        end
                    end
                end
                WRITE: begin
                    shadow_q       <= data_q;
                    shadow_valid_q <= 1'b1;
                    if (HOLD_CYCLES > 0) begin
                        state_q <= HOLD;
                        cnt_q   <= HOLD_LOAD;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                SKIP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign chipselect = chipselect_q;
    assign write_n    = write_n_q;
    assign address    = 2'b00;
    assign writedata  = writedata_q;
    assign shadow     = shadow_q;
    assign busy       = busy_q;

endmodule
